// File: rtl/simt_branch_ctrl_pkg.sv
// Shared constants and enums for the SIMT divergence controller.
package simt_branch_ctrl_pkg;

   localparam int N_CORES     = 4;
   localparam int STACK_DEPTH = 3;
   localparam int PC_W        = 8;

   // Deepest legal nesting: the bottom PStack entry holds the all-ones root mask.
   localparam logic [STACK_DEPTH:0] MAX_NEST = (STACK_DEPTH+1)'((1 << STACK_DEPTH) - 1);

   typedef logic [N_CORES-1:0] mask_t;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_IF    = 2'd1,
      OP_ELSE  = 2'd2,
      OP_ENDIF = 2'd3
   } instr_op_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_IF_PUSH   = 3'd1,
      ST_IF_CHK    = 3'd2,
      ST_ELSE_POP  = 3'd3,
      ST_ELSE_WAIT = 3'd4,
      ST_ELSE_PUSH = 3'd5,
      ST_ELSE_CHK  = 3'd6,
      ST_END_POP   = 3'd7
   } br_state_e;

endpackage

// File: rtl/simt_branch_ctrl.sv
// Divergence controller: turns IF/ELSE/ENDIF into PStack push/pop commands
// and redirects the PC when a branch side has no active cores.
module simt_branch_ctrl
   import simt_branch_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic [1:0]             instr_op,
   input  logic [N_CORES-1:0]     cond,
   input  logic [PC_W-1:0]        else_target,
   input  logic [PC_W-1:0]        endif_target,
   input  logic [N_CORES-1:0]     stk_tos,
   input  logic                   stk_all_false,
   output logic                   stk_push,
   output logic                   stk_pop,
   output logic [N_CORES-1:0]     stk_d_in,
   output logic                   redir_valid,
   output logic [PC_W-1:0]        redir_target,
   output logic [STACK_DEPTH:0]   depth,
   output logic                   err_overflow,
   output logic                   err_underflow
);

   br_state_e             state_q, state_d;
   mask_t                 taken_q, taken_d;     // IF-side mask captured at ELSE
   logic [PC_W-1:0]       else_tgt_q, else_tgt_d;
   logic [PC_W-1:0]       endif_tgt_q, endif_tgt_d;
   logic                  push_q, push_d;
   logic                  pop_q, pop_d;
   mask_t                 d_in_q, d_in_d;
   logic [STACK_DEPTH:0]  depth_q, depth_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  ready_q, ready_d;
   logic                  accept;

   assign accept = instr_valid & ready_q;

   // Next-state and registered-output computation for the sequencer.
   always_comb begin
      state_d     = state_q;
      taken_d     = taken_q;
      else_tgt_d  = else_tgt_q;
      endif_tgt_d = endif_tgt_q;
      push_d      = 1'b0;
      pop_d       = 1'b0;
      d_in_d      = '0;
      depth_d     = depth_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (instr_op_e'(instr_op))
                  OP_IF: begin
                     if (depth_q == MAX_NEST) begin
                        ovf_d = 1'b1;
                     end else begin
                        // Strobe is registered, so it appears in IF_PUSH.
                        push_d      = 1'b1;
                        d_in_d      = stk_tos & cond;
                        else_tgt_d  = else_target;
                        endif_tgt_d = endif_target;
                        state_d     = ST_IF_PUSH;
                     end
                  end
                  OP_ELSE: begin
                     if (depth_q == '0) begin
                        unf_d = 1'b1;
                     end else begin
                        pop_d       = 1'b1;
                        taken_d     = stk_tos;
                        endif_tgt_d = endif_target;
                        state_d     = ST_ELSE_POP;
                     end
                  end
                  OP_ENDIF: begin
                     if (depth_q == '0) begin
                        unf_d = 1'b1;
                     end else begin
                        pop_d   = 1'b1;
                        state_d = ST_END_POP;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_IF_PUSH: begin
            depth_d = depth_q + 1'b1;
            state_d = ST_IF_CHK;
         end
         ST_IF_CHK:    state_d = ST_IDLE;
         ST_ELSE_POP:  state_d = ST_ELSE_WAIT;
         ST_ELSE_WAIT: begin
            // Parent mask is on top now; else-side is parent minus the IF side.
            push_d  = 1'b1;
            d_in_d  = stk_tos & ~taken_q;
            state_d = ST_ELSE_PUSH;
         end
         ST_ELSE_PUSH: state_d = ST_ELSE_CHK;
         ST_ELSE_CHK:  state_d = ST_IDLE;
         ST_END_POP: begin
            depth_d = depth_q - 1'b1;
            state_d = ST_IDLE;
         end
         default:      state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // All controller state; reset aborts any sequence in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         taken_q     <= '0;
         else_tgt_q  <= '0;
         endif_tgt_q <= '0;
         push_q      <= 1'b0;
         pop_q       <= 1'b0;
         d_in_q      <= '0;
         depth_q     <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         taken_q     <= taken_d;
         else_tgt_q  <= else_tgt_d;
         endif_tgt_q <= endif_tgt_d;
         push_q      <= push_d;
         pop_q       <= pop_d;
         d_in_q      <= d_in_d;
         depth_q     <= depth_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         ready_q     <= ready_d;
      end
   end

   // all_false only reflects the new mask once in a CHK state, so the
   // redirect is decoded directly there rather than registered a cycle late.
   assign redir_valid  = stk_all_false & ((state_q == ST_IF_CHK) | (state_q == ST_ELSE_CHK));
   assign redir_target = !redir_valid            ? '0 :
                         (state_q == ST_IF_CHK)  ? else_tgt_q : endif_tgt_q;

   assign instr_ready   = ready_q;
   assign stk_push      = push_q;
   assign stk_pop       = pop_q;
   assign stk_d_in      = d_in_q;
   assign depth         = depth_q;
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;

endmodule

// File: tb/tb_simt_branch_ctrl.sv
// Bench for simt_branch_ctrl: behavioural PStack, cycle-level expectation
// model driven from the branch rules, directed cases and random traffic.
module tb_simt_branch_ctrl;
   import simt_branch_ctrl_pkg::*;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             instr_valid = 1'b0;
   logic             instr_ready;
   logic [1:0]       instr_op = 2'd0;
   logic [3:0]       cond = '0;
   logic [7:0]       else_target = '0;
   logic [7:0]       endif_target = '0;
   logic [3:0]       stk_tos;
   logic             stk_all_false;
   logic             stk_push, stk_pop;
   logic [3:0]       stk_d_in;
   logic             redir_valid;
   logic [7:0]       redir_target;
   logic [3:0]       depth;
   logic             err_overflow, err_underflow;

   always #5 clk = ~clk;

   simt_branch_ctrl dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .cond(cond), .else_target(else_target), .endif_target(endif_target),
      .stk_tos(stk_tos), .stk_all_false(stk_all_false), .stk_push(stk_push), .stk_pop(stk_pop),
      .stk_d_in(stk_d_in), .redir_valid(redir_valid), .redir_target(redir_target),
      .depth(depth), .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   // Behavioural PStack: root entry all ones, active-high reset from ~reset.
   logic [3:0] ps_mem [0:7];
   logic [2:0] ps_sp;
   wire        ps_rst = ~reset;
   always @(posedge clk or posedge ps_rst) begin
      if (ps_rst) begin
         ps_sp     <= 3'd0;
         ps_mem[0] <= 4'hF;
      end else if (stk_push) begin
         ps_mem[ps_sp + 3'd1] <= stk_d_in;
         ps_sp <= ps_sp + 3'd1;
      end else if (stk_pop) begin
         ps_sp <= ps_sp - 3'd1;
      end
   end
   assign stk_tos       = ps_mem[ps_sp];
   assign stk_all_false = (stk_tos == 4'h0);

   // Expected DUT outputs for one cycle.
   typedef struct {
      bit ready, push, pop, rv, ovf, unf;
      logic [3:0] d;
      logic [7:0] tgt;
      int depth;
   } exp_t;

   exp_t       script[$];   // pending busy cycles of the accepted instruction
   exp_t       expq[$];     // one entry per cycle, consumed by the compare process
   logic [3:0] m_stack[$];  // model mask stack, last = active mask
   int         m_depth;
   bit         m_ovf, m_unf;
   int         n_tests = 0, n_fail = 0;
   exp_t       e_cur;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic exp_t ent(bit ready, bit push, bit pop, logic [3:0] d, bit rv,
                                logic [7:0] tgt, int dep);
      exp_t e;
      e.ready = ready; e.push = push; e.pop = pop; e.d = d; e.rv = rv;
      e.tgt = rv ? tgt : 8'h00; e.depth = dep; e.ovf = m_ovf; e.unf = m_unf;
      return e;
   endfunction

   // One clock of stimulus; model advances on acceptance.
   task automatic cycle(bit rst, bit v, logic [1:0] op, logic [3:0] c,
                        logic [7:0] et, logic [7:0] nt);
      exp_t       e;
      logic [3:0] d, taken, parent;
      @(posedge clk); #1;
      reset = rst ? 1'b0 : 1'b1;
      if (rst) begin
         script.delete(); m_stack = {4'hF}; m_depth = 0; m_ovf = 0; m_unf = 0;
      end
      if (script.size() > 0) e = script.pop_front();
      else                   e = ent(1, 0, 0, 4'h0, 0, 8'h00, m_depth);
      expq.push_back(e);
      instr_valid = v & ~rst; instr_op = op; cond = c; else_target = et; endif_target = nt;
      if (e.ready && !rst && v) begin
         case (op)
            OP_IF: if (m_depth == 7) m_ovf = 1;
                   else begin
                      d = m_stack[$] & c;
                      script.push_back(ent(0, 1, 0, d, 0, 8'h00, m_depth));
                      script.push_back(ent(0, 0, 0, 4'h0, d == 4'h0, et, m_depth + 1));
                      m_depth++; m_stack.push_back(d);
                   end
            OP_ELSE: if (m_depth == 0) m_unf = 1;
                   else begin
                      taken  = m_stack[$];
                      parent = m_stack[m_stack.size()-2];
                      d      = parent & ~taken;
                      script.push_back(ent(0, 0, 1, 4'h0, 0, 8'h00, m_depth));
                      script.push_back(ent(0, 0, 0, 4'h0, 0, 8'h00, m_depth));
                      script.push_back(ent(0, 1, 0, d, 0, 8'h00, m_depth));
                      script.push_back(ent(0, 0, 0, 4'h0, d == 4'h0, nt, m_depth));
                      m_stack[m_stack.size()-1] = d;
                   end
            OP_ENDIF: if (m_depth == 0) m_unf = 1;
                   else begin
                      script.push_back(ent(0, 0, 1, 4'h0, 0, 8'h00, m_depth));
                      m_depth--; void'(m_stack.pop_back());
                   end
            default: ;
         endcase
      end
   endtask

   // Cycle followed by a sample point for literal checks.
   task automatic step(bit rst, bit v, logic [1:0] op, logic [3:0] c,
                       logic [7:0] et, logic [7:0] nt);
      cycle(rst, v, op, c, et, nt);
      @(negedge clk); #1;
   endtask

   task automatic idle_step();
      step(0, 0, OP_NONE, 4'h0, 8'h00, 8'h00);
   endtask

   task automatic do_if(logic [3:0] c);
      step(0, 1, OP_IF, c, 8'h11, 8'h22); idle_step(); idle_step();
   endtask

   task automatic do_endif();
      step(0, 1, OP_ENDIF, 4'h0, 8'h00, 8'h00); idle_step();
   endtask

   // Compare every cycle's outputs against the model expectation.
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         e_cur = expq.pop_front();
         chk("ready", instr_ready, e_cur.ready);
         chk("push", stk_push, e_cur.push);
         chk("pop", stk_pop, e_cur.pop);
         chk("d_in", stk_d_in, e_cur.d);
         chk("redir_valid", redir_valid, e_cur.rv);
         chk("redir_target", redir_target, e_cur.tgt);
         chk("depth", depth, e_cur.depth);
         chk("err_overflow", err_overflow, e_cur.ovf);
         chk("err_underflow", err_underflow, e_cur.unf);
      end
   end

   initial begin
      logic [1:0] rop;
      int         r;
      m_stack = {4'hF}; m_depth = 0; m_ovf = 0; m_unf = 0;

      // Reset state
      step(1, 0, OP_NONE, 4'h0, 8'h00, 8'h00);
      chk("rst_ready", instr_ready, 1);
      chk("rst_push", stk_push, 0);
      chk("rst_depth", depth, 0);

      // Flat IF over 1111 with cond 0101
      step(0, 1, OP_IF, 4'b0101, 8'h10, 8'h18);
      idle_step();
      chk("flat_push", stk_push, 1);
      chk("flat_d", stk_d_in, 4'b0101);
      idle_step();
      chk("flat_redir", redir_valid, 0);
      chk("flat_depth", depth, 1);
      do_endif(); idle_step();
      chk("flat_end_depth", depth, 0);

      // IF with no active cores redirects to else_target
      step(0, 1, OP_IF, 4'b0000, 8'h20, 8'h28);
      idle_step();
      idle_step();
      chk("af_redir", redir_valid, 1);
      chk("af_tgt", redir_target, 8'h20);
      do_endif();

      // IF/ELSE/ENDIF
      do_if(4'b0011);
      step(0, 1, OP_ELSE, 4'h0, 8'h00, 8'h40);
      idle_step(); idle_step(); idle_step();
      chk("else_push", stk_push, 1);
      chk("else_d", stk_d_in, 4'b1100);
      idle_step();
      chk("else_redir", redir_valid, 0);
      do_endif(); idle_step();
      chk("ie_tos", stk_tos, 4'hF);
      chk("ie_depth", depth, 0);

      // Nested: inner IF under 0011 with cond 1100
      do_if(4'b0011);
      step(0, 1, OP_IF, 4'b1100, 8'h50, 8'h60);
      idle_step();
      chk("nest_d", stk_d_in, 4'b0000);
      idle_step();
      chk("nest_redir", redir_valid, 1);
      chk("nest_tgt", redir_target, 8'h50);
      step(0, 1, OP_ELSE, 4'h0, 8'h00, 8'h60);
      idle_step(); idle_step(); idle_step();
      chk("nest_else_d", stk_d_in, 4'b0011);
      idle_step();
      chk("nest_else_redir", redir_valid, 0);
      do_endif(); do_endif();

      // Overflow at depth 7, then underflow at depth 0
      repeat (7) do_if(4'hF);
      step(0, 1, OP_IF, 4'hF, 8'h00, 8'h00);
      idle_step();
      chk("ovf_flag", err_overflow, 1);
      chk("ovf_depth", depth, 7);
      chk("ovf_push", stk_push, 0);
      repeat (7) do_endif();
      step(0, 1, OP_ENDIF, 4'h0, 8'h00, 8'h00);
      idle_step();
      chk("unf_flag", err_underflow, 1);
      chk("unf_pop", stk_pop, 0);
      chk("unf_depth", depth, 0);

      // Reset during ELSE_WAIT
      do_if(4'b0011);
      step(0, 1, OP_ELSE, 4'h0, 8'h00, 8'h70);
      idle_step();
      step(1, 0, OP_NONE, 4'h0, 8'h00, 8'h00);
      chk("rstmid_ready", instr_ready, 1);
      chk("rstmid_push", stk_push, 0);
      chk("rstmid_ovf", err_overflow, 0);
      chk("rstmid_unf", err_underflow, 0);
      for (int i = 0; i < 4; i++) begin
         idle_step();
         chk("rstmid_nopush", stk_push, 0);
      end

      // Random traffic, including valid held high while busy
      repeat (3000) begin
         r = $urandom_range(0, 9);
         rop = (r == 0) ? OP_NONE : (r <= 4) ? OP_IF : (r <= 6) ? OP_ELSE : OP_ENDIF;
         cycle(0, $urandom_range(0, 3) != 0, rop, 4'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      @(posedge clk); @(negedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
